// File: rtl/sweep_analyzer.sv
`default_nettype none
// ============================================================================
// Module      : sweep_analyzer
// Description : Receive-side companion to the triangle-wave sweep generator.
//               Watches the sweep value driven to the actuator together with a
//               detector signal and emits one record per half-sweep: direction,
//               sweep extremes, half-period length and the sweep position of
//               the detector peak (and optionally trough).
// Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
// Optional feature macro: SWEEP_ANALYZER_TROUGH_EN
//   defined     -> trough tracker built, trough_* outputs valid with the record
//   not defined -> trough logic omitted, trough_pos_out/trough_val_out tied to 0
// ----------------------------------------------------------------------------
// Ports
//   clk_in          system clock, rising edge
//   rst_n_in        asynchronous active-low reset
//   on_in           enable; low clears back to IDLE on the next edge
//   sweep_in        sweep value (signed, SWEEP_SIZE)
//   signal_in       detector/error signal (signed, SIGNAL_SIZE)
//   valid_out       1-cycle pulse, record outputs updated this cycle
//   dir_out         direction of completed half-sweep (0 up, 1 down)
//   min_out/max_out sweep extremes of completed half-sweep
//   halfperiod_out  samples in completed half-sweep, saturating
//   peak_pos_out    sweep value at max signal_in, peak_val_out that maximum
//   trough_pos_out  sweep value at min signal_in, trough_val_out that minimum
// ============================================================================
module sweep_analyzer #(
  parameter int SWEEP_SIZE  = 18,
  parameter int SIGNAL_SIZE = 16,
  parameter int PERIOD_SIZE = 32,
  parameter int DEADBAND    = 0
) (
  input  logic                          clk_in,
  input  logic                          rst_n_in,
  input  logic                          on_in,
  input  logic signed [SWEEP_SIZE-1:0]  sweep_in,
  input  logic signed [SIGNAL_SIZE-1:0] signal_in,
  output logic                          valid_out,
  output logic                          dir_out,
  output logic signed [SWEEP_SIZE-1:0]  min_out,
  output logic signed [SWEEP_SIZE-1:0]  max_out,
  output logic        [PERIOD_SIZE-1:0] halfperiod_out,
  output logic signed [SWEEP_SIZE-1:0]  peak_pos_out,
  output logic signed [SIGNAL_SIZE-1:0] peak_val_out,
  output logic signed [SWEEP_SIZE-1:0]  trough_pos_out,
  output logic signed [SIGNAL_SIZE-1:0] trough_val_out
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACQ  = 2'd1,
    ST_UP   = 2'd2,
    ST_DOWN = 2'd3
  } state_t;

  localparam logic signed [SWEEP_SIZE:0] C_DB_POS  = (SWEEP_SIZE+1)'(DEADBAND);
  localparam logic        [PERIOD_SIZE-1:0] C_ONE  = PERIOD_SIZE'(1);
  localparam logic        [PERIOD_SIZE-1:0] C_TWO  = PERIOD_SIZE'(2);

  state_t state_q, state_d;

  // input registers and previous sample
  logic signed [SWEEP_SIZE-1:0]  s_q, s_d, s_prev_q, s_prev_d;
  logic signed [SIGNAL_SIZE-1:0] x_q, x_d, x_prev_q, x_prev_d;
  logic                          prev_vld_q, prev_vld_d;

  // half-sweep trackers
  logic signed [SWEEP_SIZE-1:0]  min_q, min_d, max_q, max_d;
  logic        [PERIOD_SIZE-1:0] cnt_q, cnt_d;
  logic signed [SWEEP_SIZE-1:0]  pk_pos_q, pk_pos_d;
  logic signed [SIGNAL_SIZE-1:0] pk_val_q, pk_val_d;

  // record registers
  logic                          valid_q, valid_d, dir_q, dir_d;
  logic signed [SWEEP_SIZE-1:0]  rmin_q, rmin_d, rmax_q, rmax_d;
  logic        [PERIOD_SIZE-1:0] rhp_q, rhp_d;
  logic signed [SWEEP_SIZE-1:0]  rpk_pos_q, rpk_pos_d;
  logic signed [SIGNAL_SIZE-1:0] rpk_val_q, rpk_val_d;

  // tracker control decoded by the FSM
  logic w_clr, w_seed2, w_seed1, w_acc, w_emit;
  logic signed [SWEEP_SIZE:0] delta;
  logic w_rise, w_fall;

  // one extra bit so full-scale swings cannot wrap
  assign delta  = $signed({s_q[SWEEP_SIZE-1], s_q}) - $signed({s_prev_q[SWEEP_SIZE-1], s_prev_q});
  assign w_rise = prev_vld_q && (delta > C_DB_POS);
  assign w_fall = prev_vld_q && (delta < -C_DB_POS);

  assign s_d = sweep_in;
  assign x_d = signal_in;

  // next state and tracker control
  always_comb begin
    state_d    = state_q;
    prev_vld_d = prev_vld_q;
    s_prev_d   = s_prev_q;
    x_prev_d   = x_prev_q;
    w_clr      = 1'b0;
    w_seed2    = 1'b0;
    w_seed1    = 1'b0;
    w_acc      = 1'b0;
    w_emit     = 1'b0;
    if (!on_in) begin
      state_d    = ST_IDLE;
      prev_vld_d = 1'b0;
      w_clr      = 1'b1;
    end else begin
      if (state_q != ST_IDLE) begin
        prev_vld_d = 1'b1;
        s_prev_d   = s_q;
        x_prev_d   = x_q;
      end
      case (state_q)
        ST_IDLE: state_d = ST_ACQ;
        ST_ACQ: begin
          // The pair that establishes the direction both belong to the new
          // half-sweep: the previous sample is where the movement started.
          if (w_rise) begin
            state_d = ST_UP;
            w_seed2 = 1'b1;
          end else if (w_fall) begin
            state_d = ST_DOWN;
            w_seed2 = 1'b1;
          end
        end
        ST_UP: begin
          if (w_fall) begin
            state_d = ST_DOWN;
            w_emit  = 1'b1;
            w_seed1 = 1'b1;
          end else begin
            w_acc = 1'b1;
          end
        end
        ST_DOWN: begin
          if (w_rise) begin
            state_d = ST_UP;
            w_emit  = 1'b1;
            w_seed1 = 1'b1;
          end else begin
            w_acc = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // trackers: reversing sample opens the new half-sweep, never closes the old
  always_comb begin
    min_d    = min_q;
    max_d    = max_q;
    cnt_d    = cnt_q;
    pk_pos_d = pk_pos_q;
    pk_val_d = pk_val_q;
    if (w_clr) begin
      min_d    = '0;
      max_d    = '0;
      cnt_d    = '0;
      pk_pos_d = '0;
      pk_val_d = '0;
    end else if (w_seed2) begin
      min_d = (s_q < s_prev_q) ? s_q : s_prev_q;
      max_d = (s_q > s_prev_q) ? s_q : s_prev_q;
      cnt_d = C_TWO;
      if (x_q > x_prev_q) begin
        pk_pos_d = s_q;
        pk_val_d = x_q;
      end else begin
        pk_pos_d = s_prev_q;
        pk_val_d = x_prev_q;
      end
    end else if (w_seed1) begin
      min_d    = s_q;
      max_d    = s_q;
      cnt_d    = C_ONE;
      pk_pos_d = s_q;
      pk_val_d = x_q;
    end else if (w_acc) begin
      if (s_q < min_q) min_d = s_q;
      if (s_q > max_q) max_d = s_q;
      if (!(&cnt_q)) cnt_d = cnt_q + C_ONE;
      // strictly greater: ties keep the earliest position
      if (x_q > pk_val_q) begin
        pk_pos_d = s_q;
        pk_val_d = x_q;
      end
    end
  end

  // record: loads from the closing half-sweep on the reversing cycle
  always_comb begin
    valid_d   = w_emit;
    dir_d     = dir_q;
    rmin_d    = rmin_q;
    rmax_d    = rmax_q;
    rhp_d     = rhp_q;
    rpk_pos_d = rpk_pos_q;
    rpk_val_d = rpk_val_q;
    if (w_emit) begin
      dir_d     = (state_q == ST_DOWN);
      rmin_d    = min_q;
      rmax_d    = max_q;
      rhp_d     = cnt_q;
      rpk_pos_d = pk_pos_q;
      rpk_val_d = pk_val_q;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q    <= ST_IDLE;
      s_q        <= '0;
      x_q        <= '0;
      s_prev_q   <= '0;
      x_prev_q   <= '0;
      prev_vld_q <= 1'b0;
      min_q      <= '0;
      max_q      <= '0;
      cnt_q      <= '0;
      pk_pos_q   <= '0;
      pk_val_q   <= '0;
      valid_q    <= 1'b0;
      dir_q      <= 1'b0;
      rmin_q     <= '0;
      rmax_q     <= '0;
      rhp_q      <= '0;
      rpk_pos_q  <= '0;
      rpk_val_q  <= '0;
    end else begin
      state_q    <= state_d;
      s_q        <= s_d;
      x_q        <= x_d;
      s_prev_q   <= s_prev_d;
      x_prev_q   <= x_prev_d;
      prev_vld_q <= prev_vld_d;
      min_q      <= min_d;
      max_q      <= max_d;
      cnt_q      <= cnt_d;
      pk_pos_q   <= pk_pos_d;
      pk_val_q   <= pk_val_d;
      valid_q    <= valid_d;
      dir_q      <= dir_d;
      rmin_q     <= rmin_d;
      rmax_q     <= rmax_d;
      rhp_q      <= rhp_d;
      rpk_pos_q  <= rpk_pos_d;
      rpk_val_q  <= rpk_val_d;
    end
  end

  assign valid_out      = valid_q;
  assign dir_out        = dir_q;
  assign min_out        = rmin_q;
  assign max_out        = rmax_q;
  assign halfperiod_out = rhp_q;
  assign peak_pos_out   = rpk_pos_q;
  assign peak_val_out   = rpk_val_q;

`ifdef SWEEP_ANALYZER_TROUGH_EN
  logic signed [SWEEP_SIZE-1:0]  tr_pos_q, tr_pos_d, rtr_pos_q, rtr_pos_d;
  logic signed [SIGNAL_SIZE-1:0] tr_val_q, tr_val_d, rtr_val_q, rtr_val_d;

  always_comb begin
    tr_pos_d  = tr_pos_q;
    tr_val_d  = tr_val_q;
    rtr_pos_d = rtr_pos_q;
    rtr_val_d = rtr_val_q;
    if (w_emit) begin
      rtr_pos_d = tr_pos_q;
      rtr_val_d = tr_val_q;
    end
    if (w_clr) begin
      tr_pos_d = '0;
      tr_val_d = '0;
    end else if (w_seed2) begin
      if (x_q < x_prev_q) begin
        tr_pos_d = s_q;
        tr_val_d = x_q;
      end else begin
        tr_pos_d = s_prev_q;
        tr_val_d = x_prev_q;
      end
    end else if (w_seed1) begin
      tr_pos_d = s_q;
      tr_val_d = x_q;
    end else if (w_acc && (x_q < tr_val_q)) begin
      tr_pos_d = s_q;
      tr_val_d = x_q;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      tr_pos_q  <= '0;
      tr_val_q  <= '0;
      rtr_pos_q <= '0;
      rtr_val_q <= '0;
    end else begin
      tr_pos_q  <= tr_pos_d;
      tr_val_q  <= tr_val_d;
      rtr_pos_q <= rtr_pos_d;
      rtr_val_q <= rtr_val_d;
    end
  end

  assign trough_pos_out = rtr_pos_q;
  assign trough_val_out = rtr_val_q;
`else
  assign trough_pos_out = '0;
  assign trough_val_out = '0;
`endif

endmodule
`default_nettype wire
